vedic_mult_pipe: RTL and testbench

VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

---
 rtl/vedic_pkg.sv | 14 +
 rtl/vedic_core.sv | 40 ++++
 rtl/vedic_mult_pipe.sv | 85 ++++++++
 tb/tb_vedic_mult_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants, stage-valid type and WIDTH legality check for the Vedic
// multiplier pipeline.
package vedic_pkg;

    localparam int LATENCY = 3;

    // One valid bit per pipeline stage; bit 0 is S1, bit LATENCY-1 is S3.
    typedef logic [LATENCY-1:0] stage_valid_t;

    function automatic bit width_legal(input int w);
        return (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational recursive Urdhva-Tiryagbhyam NxN multiplier; N must be a power
// of two >= 2. Each level splits into four N/2 products, bottoming out at 2x2.
module vedic_core #(
    parameter int N = 2
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);

    if (N == 2) begin : g_cell
        logic pp00, pp01, pp10, pp11, carry1;

        assign pp00   = x[0] & y[0];
        assign pp01   = x[0] & y[1];
        assign pp10   = x[1] & y[0];
        assign pp11   = x[1] & y[1];
        assign carry1 = pp01 & pp10;

        assign p[0] = pp00;
        assign p[1] = pp01 ^ pp10;
        assign p[2] = pp11 ^ carry1;
        assign p[3] = pp11 & carry1;
    end else begin : g_split
        localparam int H = N / 2;

        logic [N-1:0] hh, hl, lh, ll;

        vedic_core #(.N(H)) u_hh (.x(x[N-1:H]), .y(y[N-1:H]), .p(hh));
        vedic_core #(.N(H)) u_hl (.x(x[N-1:H]), .y(y[H-1:0]), .p(hl));
        vedic_core #(.N(H)) u_lh (.x(x[H-1:0]), .y(y[N-1:H]), .p(lh));
        vedic_core #(.N(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(ll));

        // Cross products sit H bits up; hh/ll concatenate without overlap.
        assign p = {hh, ll}
                 + {{H{1'b0}}, hl, {H{1'b0}}}
                 + {{H{1'b0}}, lh, {H{1'b0}}};
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Vedic multiplier, c = a*b at full 2*WIDTH precision.
// Define VEDIC_SIGNED_EN for two's-complement operands (sign-magnitude inside).
module vedic_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] c,
    output logic               out_valid,
    input  logic               out_ready
);
    import vedic_pkg::*;

    localparam int H = WIDTH / 2;

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances together (adv); in_ready == adv depends only on
    // registered out_valid and out_ready, so nothing flows from in_valid.
    stage_valid_t       vld;
    logic               adv;
    logic [WIDTH-1:0]   a1, b1;
    logic [WIDTH-1:0]   hh_w, hl_w, lh_w, ll_w;
    logic [WIDTH-1:0]   hh2, hl2, lh2, ll2;
    logic [2*WIDTH-1:0] sum2;
`ifdef VEDIC_SIGNED_EN
    logic               neg1, neg2;
`endif

    assign adv       = !vld[LATENCY-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LATENCY-1];

    vedic_core #(.N(H)) u_hh (.x(a1[WIDTH-1:H]), .y(b1[WIDTH-1:H]), .p(hh_w));
    vedic_core #(.N(H)) u_hl (.x(a1[WIDTH-1:H]), .y(b1[H-1:0]),     .p(hl_w));
    vedic_core #(.N(H)) u_lh (.x(a1[H-1:0]),     .y(b1[WIDTH-1:H]), .p(lh_w));
    vedic_core #(.N(H)) u_ll (.x(a1[H-1:0]),     .y(b1[H-1:0]),     .p(ll_w));

    assign sum2 = {hh2, ll2}
                + {{H{1'b0}}, hl2, {H{1'b0}}}
                + {{H{1'b0}}, lh2, {H{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            a1  <= '0;
            b1  <= '0;
            hh2 <= '0;
            hl2 <= '0;
            lh2 <= '0;
            ll2 <= '0;
            c   <= '0;
`ifdef VEDIC_SIGNED_EN
            neg1 <= 1'b0;
            neg2 <= 1'b0;
`endif
        end else if (adv) begin
            vld <= {vld[LATENCY-2:0], in_valid};
`ifdef VEDIC_SIGNED_EN
            // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
            a1   <= a[WIDTH-1] ? -a : a;
            b1   <= b[WIDTH-1] ? -b : b;
            neg1 <= a[WIDTH-1] ^ b[WIDTH-1];
            neg2 <= neg1;
            c    <= neg2 ? -sum2 : sum2;
`else
            a1 <= a;
            b1 <= b;
            c  <= sum2;
`endif
            hh2 <= hh_w;
            hl2 <= hl_w;
            lh2 <= lh_w;
            ll2 <= ll_w;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe (WIDTH=8 main DUT, WIDTH=16 side DUT);
// honours VEDIC_SIGNED_EN for the reference model and directed constants.
module tb_vedic_mult_pipe;

    localparam int W   = 8;
    localparam int W16 = 16;
    localparam int LAT = 3;

`ifdef VEDIC_SIGNED_EN
    localparam logic [2*W-1:0]   FF_SQ   = 16'h0001;
    localparam logic [2*W16-1:0] FFFF_SQ = 32'h0000_0001;
`else
    localparam logic [2*W-1:0]   FF_SQ   = 16'd65025;
    localparam logic [2*W16-1:0] FFFF_SQ = 32'hFFFE_0001;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    logic [W-1:0]     a, b;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [2*W-1:0]   c;

    logic [W16-1:0]   a16, b16;
    logic             in_valid16, in_ready16, out_valid16, out_ready16;
    logic [2*W16-1:0] c16;

    vedic_mult_pipe #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .out_valid(out_valid), .out_ready(out_ready)
    );

    vedic_mult_pipe #(.WIDTH(W16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .c(c16), .out_valid(out_valid16), .out_ready(out_ready16)
    );

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [2*W-1:0] exp_q[$];
    int             cyc_q[$];
    bit             chk_lat  = 1'b0;
    bit             rand_done;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model: plain integer arithmetic on the operand interpretation.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef VEDIC_SIGNED_EN
        logic signed [2*W-1:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
`else
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
        bit done;
        done = 1'b0;
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                cyc_q.push_back(cyc);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) fail_now("send_accept");
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) fail_now("drain");
        repeat (2) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got 0x%0h with no result pending (cycle %0d)", c, cyc);
            end else begin
                check("product", 64'(c), 64'(exp_q[0]));
                if (out_ready) begin
                    check("in_ready_flow", 64'(in_ready), 64'd1);
                    if (chk_lat) check("latency", 64'(cyc - cyc_q[0]), 64'(LAT));
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                end else begin
                    check("in_ready_stall", 64'(in_ready), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", 64'(c), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst16_out_valid", 64'(out_valid16), 64'd0);
        check("rst16_c", 64'(c16), 64'd0);

        // WIDTH=16 side DUT: two back-to-back products at fixed latency.
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0010;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        #1;
        check("w16_valid0", 64'(out_valid16), 64'd1);
        check("w16_ffff", 64'(c16), 64'(FFFF_SQ));
        @(negedge clk);
        #1;
        check("w16_valid1", 64'(out_valid16), 64'd1);
        check("w16_1234", 64'(c16), 64'h0001_2340);
        @(negedge clk);
        #1;
        check("w16_idle", 64'(out_valid16), 64'd0);

        // Zero operands, latency measured.
        chk_lat = 1'b1;
        send(8'd0, 8'd0, 16'h0000);
        idle();
        drain();

        // Back-to-back stream, no stall.
        send(8'd255, 8'd255, FF_SQ);
        send(8'd5, 8'd3, 16'd15);
        send(8'd4, 8'd2, 16'd8);
        send(8'd2, 8'd2, 16'd4);
        send(8'd6, 8'd8, 16'd48);
        idle();
        drain();

        // Same stream with 4 stalled cycles on the first result.
        chk_lat = 1'b0;
        fork
            begin
                send(8'd255, 8'd255, FF_SQ);
                send(8'd5, 8'd3, 16'd15);
                send(8'd4, 8'd2, 16'd8);
                send(8'd2, 8'd2, 16'd4);
                send(8'd6, 8'd8, 16'd48);
                idle();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) fail_now("stall_first_result");
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while (5,3) is in flight.
        send(8'd5, 8'd3, 16'd15);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("flush_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

`ifdef VEDIC_SIGNED_EN
        chk_lat = 1'b1;
        send(8'hFF, 8'hFF, 16'h0001);
        send(8'h80, 8'h7F, 16'hC080);
        send(8'h80, 8'h80, 16'h4000);
        idle();
        drain();
        chk_lat = 1'b0;
`endif

        // Randomised operands, gaps and back-pressure.
        rand_done = 1'b0;
        fork
            begin
                send(8'hFF, 8'h00, ref_mul(8'hFF, 8'h00));
                send(8'h80, 8'hFF, ref_mul(8'h80, 8'hFF));
                for (int i = 0; i < 200; i++) begin
                    logic [W-1:0] x, y;
                    if ($urandom_range(0, 3) == 0) idle();
                    x = W'($urandom);
                    y = W'($urandom);
                    send(x, y, ref_mul(x, y));
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
